rr_ring_scheduler: RTL and testbench
====================================

# rr_ring_scheduler

Round-robin access scheduler for a single shared resource, driven by a rotating one-hot token in the style of the team's ring counter. Up to N requesters raise level requests. The block grants exactly one requester at a time, holds the grant until the requester releases it or a hold limit expires, then passes the token to the next ring position. It sits between the requester blocks and the resource's enable/select mux.

## Interface
- N, 4, number of requesters (≥2)
- MAX_HOLD, 8, maximum consecutive grant cycles per requester (≥1; used only with RR_SCHED_TIMEOUT_EN)
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- en  input  1  scheduler enable; gates new grants only
- req  input  N  level request per requester
- gnt  output  N  one-hot grant, registered
- gnt_valid  output  1  high when any gnt bit is high
- gnt_id  output  $clog2(N)  index of granted requester; holds last winner when gnt_valid=0
- token  output  N  one-hot ring pointer: highest-priority position for the next arbitration
- preempt  output  1  one-cycle pulse when a grant is ended by hold-limit expiry

## Operation
- Reset values: state=IDLE, token=1 (bit 0), gnt=0, gnt_valid=0, gnt_id=0, preempt=0, hold_cnt=0.
- State IDLE:
  - If en=1 and req≠0, select the first set req bit at or after token, scanning upward with wrap N-1→0.
  - The winner is registered into gnt and gnt_id, token is set to the winner, and the state moves to GRANT.
  - Otherwise stay in IDLE.
- State GRANT:
  - gnt is held; hold_cnt increments each cycle, width $clog2(MAX_HOLD)+1, no wrap.
  - Exit when req[gnt_id]=0, or (with the macro) when hold_cnt=MAX_HOLD-1.
  - On exit: gnt is cleared, token rotates to (gnt_id+1) mod N, hold_cnt is cleared, and the state moves to GAP.
  - preempt=1 for the exit cycle only when exit is by expiry and req[gnt_id] is still 1.
  - If the requester drops req on the expiry cycle, the exit counts as a release (preempt=0).
- State GAP: exactly one cycle with gnt=0, giving the resource a turnaround cycle. Arbitration runs as in IDLE; on a winner go to GRANT, otherwise go to IDLE.
- Requests from non-granted requesters never affect an active grant.
- en=0 in GRANT: the current grant runs to normal completion. en=0 in IDLE/GAP: no grant is issued; token is unchanged.
- Reset asserted mid-grant: all outputs return to their reset values immediately (asynchronous). There is no partial-grant recovery.

## Timing
- Grant latency:
  - A req sampled high at edge k in IDLE/GAP gives gnt high after edge k.
  - A request rising in cycle t is sampled at the next edge, so gnt appears one cycle after req.
- Release latency: req[gnt_id] sampled low at edge k gives gnt low after edge k (same edge).
- Minimum gap between consecutive grants: 1 cycle at gnt=0.
- With requests saturated, each requester gets MAX_HOLD cycles followed by 1 gap cycle, so the ring period is N·(MAX_HOLD+1).
- Invariant: gnt is always 0 or one-hot, and token is always one-hot.
- Reset release: the first grant is possible at the first edge after clr_n deasserts.

## Configuration
- RR_SCHED_TIMEOUT_EN defined:
  - The hold limit is active.
  - preempt is generated.
  - Starvation is bounded to (N-1)·(MAX_HOLD+1) cycles.
- Not defined:
  - A grant lasts until its req drops.
  - preempt is tied 0.
  - hold_cnt logic is removed, and MAX_HOLD is ignored.

## Test plan
All scenarios use N=4 and MAX_HOLD=8.
- Reset:
  - Stimulus: clr_n=0 while gnt=0100.
  - Response: gnt=0, gnt_valid=0, gnt_id=0, token=0001, preempt=0 with no clock edge; no grant occurs before clr_n=1.
- Single requester:
  - Stimulus: en=1, req=0100 held 3 cycles, then 0.
  - Response: gnt=0100 and gnt_id=2 one cycle after req rises, for 3 cycles; gnt=0 after the drop edge; token=1000.
- Saturation, with the macro:
  - Stimulus: req=1111 constant.
  - Response: gnt sequence 0001, 0010, 0100, 1000, 0001, each 8 cycles, separated by one gnt=0 cycle; preempt pulses once per grant.
- Wrap-around:
  - Stimulus: token=1000, req=0011.
  - Response: gnt=0001 first; after release, token=0010, then gnt=0010.
- Enable gating:
  - Stimulus 1: en=0 with req=1111 → gnt stays 0.
  - Stimulus 2: en dropped during gnt=0010 → the grant completes normally, and no new grant is issued while en=0.
- Without the macro:
  - Stimulus: req=0010 held 20 cycles.
  - Response: gnt=0010 held all 20 cycles, and preempt stays 0.

Source files
------------

// File: rtl/rr_ring_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_ring_scheduler_if
// Description : Request/grant bundle between requesters and rr_ring_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_ring_scheduler_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   token;
    logic           preempt;

    modport master (
        output en, req,
        input  gnt, gnt_valid, gnt_id, token, preempt
    );

    modport slave (
        input  en, req,
        output gnt, gnt_valid, gnt_id, token, preempt
    );
endinterface
`default_nettype wire

// File: rtl/rr_ring_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_ring_scheduler
// Description : Token-ring round-robin scheduler for one shared resource.
//               Optional hold-limit preemption enabled by RR_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_ring_scheduler #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  wire logic          clk,
    input  wire logic          clr_n,
    rr_ring_scheduler_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_gnt;
    logic           r_gnt_valid;
    logic [IDW-1:0] r_gnt_id;
    logic [N-1:0]   r_token;
    logic           r_preempt;

    logic [IDW-1:0] w_tok_idx;
    logic           w_found;
    logic [IDW-1:0] w_win_id;
    logic [IDW-1:0] w_next_id;
    logic           w_release;
    logic           w_expire;

    function automatic logic [N-1:0] f_onehot(input logic [IDW-1:0] id);
        logic [N-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    always_comb begin
        w_tok_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_token[i]) w_tok_idx = IDW'(i);
        end
    end

    // Scan upward from the token position, wrapping N-1 -> 0.
    always_comb begin
        logic [IDW:0] v_scan;
        w_found  = 1'b0;
        w_win_id = '0;
        v_scan   = '0;
        for (int i = 0; i < N; i++) begin
            v_scan = {1'b0, w_tok_idx} + (IDW+1)'(i);
            if (v_scan >= (IDW+1)'(N)) v_scan = v_scan - (IDW+1)'(N);
            if (!w_found && bus.req[v_scan[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_win_id = v_scan[IDW-1:0];
            end
        end
    end

    assign w_next_id = (r_gnt_id == IDW'(N-1)) ? '0 : r_gnt_id + IDW'(1);
    assign w_release = ~bus.req[r_gnt_id];

`ifdef RR_SCHED_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD) + 1;
    logic [HCW-1:0] r_hold_cnt;

    assign w_expire = (r_state == ST_GRANT) && (r_hold_cnt == HCW'(MAX_HOLD-1));

    // Counts completed grant cycles; saturates rather than wrapping.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_GRANT && !(w_release || w_expire)) begin
            if (r_hold_cnt != HCW'(MAX_HOLD-1)) r_hold_cnt <= r_hold_cnt + HCW'(1);
        end else begin
            r_hold_cnt <= '0;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_token     <= f_onehot('0);
            r_preempt   <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (bus.en && w_found) begin
                        r_gnt       <= f_onehot(w_win_id);
                        r_gnt_valid <= 1'b1;
                        r_gnt_id    <= w_win_id;
                        r_token     <= f_onehot(w_win_id);
                        r_state     <= ST_GRANT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // A drop on the expiry cycle is treated as a normal release.
                    if (w_release || w_expire) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_token     <= f_onehot(w_next_id);
                        r_preempt   <= w_expire && !w_release;
                        r_state     <= ST_GAP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.token     = r_token;
    assign bus.preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_ring_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_ring_scheduler
// Description : Self-checking bench for rr_ring_scheduler (N=4, MAX_HOLD=8);
//               covers RR_SCHED_TIMEOUT_EN both defined and undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_ring_scheduler;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic clr_n;

    rr_ring_scheduler_if #(.N(N)) bus ();

    rr_ring_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] id;
        logic [3:0] token;
        logic       preempt;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] req;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [3:0] g, input logic v, input int id,
                                input logic [3:0] t, input logic p);
        exp_t r;
        r.gnt     = g;
        r.valid   = v;
        r.id      = id[1:0];
        r.token   = t;
        r.preempt = p;
        return r;
    endfunction

    function automatic vec_t mkv(input logic en, input logic [3:0] req, input exp_t e);
        vec_t r;
        r.en  = en;
        r.req = req;
        r.e   = e;
        return r;
    endfunction

    function automatic logic [3:0] oh(input int id);
        logic [3:0] one;
        one = 4'b0001;
        return one << id;
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.token, bus.preempt};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got gnt=%b valid=%b id=%0d token=%b preempt=%b, expected gnt=%b valid=%b id=%0d token=%b preempt=%b",
                     name, a.gnt, a.valid, a.id, a.token, a.preempt,
                     e.gnt, e.valid, e.id, e.token, e.preempt);
        end
    endtask

    task automatic step(input string name, input logic en, input logic [3:0] req, input exp_t e);
        @(negedge clk);
        bus.en  = en;
        bus.req = req;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(name, sb_q.pop_front());
    endtask

    vec_t vt[20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mkv(1, 4'b0000, mk(4'b0000, 0, 0, 4'b0001, 0));
        vt[1]  = mkv(1, 4'b0100, mk(4'b0100, 1, 2, 4'b0100, 0));
        vt[2]  = mkv(1, 4'b0100, mk(4'b0100, 1, 2, 4'b0100, 0));
        vt[3]  = mkv(1, 4'b0100, mk(4'b0100, 1, 2, 4'b0100, 0));
        vt[4]  = mkv(1, 4'b0000, mk(4'b0000, 0, 2, 4'b1000, 0));
        vt[5]  = mkv(1, 4'b0000, mk(4'b0000, 0, 2, 4'b1000, 0));
        vt[6]  = mkv(1, 4'b0011, mk(4'b0001, 1, 0, 4'b0001, 0));
        vt[7]  = mkv(1, 4'b0011, mk(4'b0001, 1, 0, 4'b0001, 0));
        vt[8]  = mkv(1, 4'b0010, mk(4'b0000, 0, 0, 4'b0010, 0));
        vt[9]  = mkv(1, 4'b0010, mk(4'b0010, 1, 1, 4'b0010, 0));
        vt[10] = mkv(1, 4'b0010, mk(4'b0010, 1, 1, 4'b0010, 0));
        vt[11] = mkv(0, 4'b0010, mk(4'b0010, 1, 1, 4'b0010, 0));
        vt[12] = mkv(0, 4'b0000, mk(4'b0000, 0, 1, 4'b0100, 0));
        vt[13] = mkv(0, 4'b1111, mk(4'b0000, 0, 1, 4'b0100, 0));
        vt[14] = mkv(0, 4'b1111, mk(4'b0000, 0, 1, 4'b0100, 0));
        vt[15] = mkv(1, 4'b1111, mk(4'b0100, 1, 2, 4'b0100, 0));
        vt[16] = mkv(1, 4'b1011, mk(4'b0000, 0, 2, 4'b1000, 0));
        vt[17] = mkv(1, 4'b1011, mk(4'b1000, 1, 3, 4'b1000, 0));
        vt[18] = mkv(1, 4'b0011, mk(4'b0000, 0, 3, 4'b0001, 0));
        vt[19] = mkv(1, 4'b0000, mk(4'b0000, 0, 3, 4'b0001, 0));

        clr_n   = 1'b0;
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_initial", mk(4'b0000, 0, 0, 4'b0001, 0));
        @(negedge clk);
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        clr_n   = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("table_vec%0d", i), vt[i].en, vt[i].req, vt[i].e);
        end

        // Asynchronous reset in the middle of a grant.
        step("pre_reset_grant", 1, 4'b0100, mk(4'b0100, 1, 2, 4'b0100, 0));
        #3;
        clr_n = 1'b0;
        #1;
        compare("async_reset_no_edge", mk(4'b0000, 0, 0, 4'b0001, 0));
        step("reset_held_1", 1, 4'b1111, mk(4'b0000, 0, 0, 4'b0001, 0));
        step("reset_held_2", 1, 4'b1111, mk(4'b0000, 0, 0, 4'b0001, 0));
        @(negedge clk);
        clr_n = 1'b1;
        sb_q.push_back(mk(4'b0001, 1, 0, 4'b0001, 0));
        @(posedge clk);
        #1;
        compare("first_grant_after_reset", sb_q.pop_front());
        step("post_reset_release", 1, 4'b0000, mk(4'b0000, 0, 0, 4'b0010, 0));
        step("post_reset_idle", 1, 4'b0000, mk(4'b0000, 0, 0, 4'b0010, 0));

`ifdef RR_SCHED_TIMEOUT_EN
        for (int g = 0; g < 5; g++) begin
            int id;
            id = (1 + g) % 4;
            for (int c = 0; c < MAX_HOLD; c++) begin
                step($sformatf("sat_g%0d_c%0d", g, c), 1, 4'b1111, mk(oh(id), 1, id, oh(id), 0));
            end
            step($sformatf("sat_g%0d_expire", g), 1, 4'b1111, mk(4'b0000, 0, id, oh((id + 1) % 4), 1));
        end
        for (int c = 0; c < MAX_HOLD; c++) begin
            step($sformatf("drop_on_expiry_c%0d", c), 1, 4'b1111, mk(4'b0100, 1, 2, 4'b0100, 0));
        end
        step("drop_on_expiry_exit", 1, 4'b1011, mk(4'b0000, 0, 2, 4'b1000, 0));
        step("drop_on_expiry_idle", 1, 4'b0000, mk(4'b0000, 0, 2, 4'b1000, 0));
`else
        for (int c = 0; c < 20; c++) begin
            step($sformatf("long_hold_c%0d", c), 1, 4'b0010, mk(4'b0010, 1, 1, 4'b0010, 0));
        end
        step("long_hold_release", 1, 4'b0000, mk(4'b0000, 0, 1, 4'b0100, 0));
        step("long_hold_idle", 1, 4'b0000, mk(4'b0000, 0, 1, 4'b0100, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
